// File: rtl/mul_iter_pkg.sv
// rtl/mul_iter_pkg.sv - op/state encodings and iteration count shared with the RV32I core
package mul_iter_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_SIGN = 2'b10,
    ST_DONE = 2'b11
  } mul_state_e;

  localparam int MUL_ITERS = 32;

  function automatic logic op_rs1_signed(input mul_op_e o);
    return (o == OP_MULH) || (o == OP_MULHSU);
  endfunction

  function automatic logic op_rs2_signed(input mul_op_e o);
    return (o == OP_MULH);
  endfunction

endpackage

// File: rtl/mul_iter_fulladder.sv
// rtl/mul_iter_fulladder.sv - 32-bit ripple-carry adder
module fulladder (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        P_in,
  output logic [31:0] S,
  output logic        P_out
);

  logic [32:0] c;

  always_comb begin
    c    = '0;
    S    = '0;
    c[0] = P_in;
    for (int i = 0; i < 32; i++) begin
      S[i]     = A[i] ^ B[i] ^ c[i];
      c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    P_out = c[32];
  end

endmodule

// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - iterative 32x32 shift-add multiplier (MUL/MULH/MULHSU/MULHU)
// Multiplies operand magnitudes over 32 cycles, then fixes the sign in one cycle.
module mul_iter
  import mul_iter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  mul_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  mul_op_e     op_q, op_d;
  logic        sign_q, sign_d;

  mul_op_e     op_in;
  logic        s1, s2;
  logic [31:0] mag1, mag2;
  logic [31:0] add_b, add_sum;
  logic        add_cout;

  // Adding zero when the multiplier LSB is clear keeps one shift path for both cases.
  assign add_b = acc_q[0] ? mcand_q : 32'd0;

  fulladder u_add (
    .A     (acc_q[63:32]),
    .B     (add_b),
    .P_in  (1'b0),
    .S     (add_sum),
    .P_out (add_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    op_d    = op_q;
    sign_d  = sign_q;

    op_in = mul_op_e'(op);
    s1    = op_rs1_signed(op_in) & rs1[31];
    s2    = op_rs2_signed(op_in) & rs2[31];
    // 0x80000000 negates to itself, which read unsigned is the magnitude 2^31.
    mag1  = s1 ? (~rs1 + 32'd1) : rs1;
    mag2  = s2 ? (~rs2 + 32'd1) : rs2;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = op_in;
          sign_d  = s1 ^ s2;
          mcand_d = mag1;
          acc_d   = {33'd0, mag2};
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d = {add_cout, add_sum, acc_q[31:0]} >> 1;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(MUL_ITERS - 1)) begin
          state_d = ST_SIGN;
        end
      end
      ST_SIGN: begin
        if (sign_q) begin
          acc_d = ~acc_q + 65'd1;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      op_q    <= OP_MUL;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = !out_valid       ? 32'd0 :
                     (op_q == OP_MUL) ? acc_q[31:0] : acc_q[63:32];

endmodule

// File: tb/tb_mul_iter.sv
// tb/tb_mul_iter.sv - self-checking bench for mul_iter
module tb_mul_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int n_vec = 0;
  int n_bad = 0;

  mul_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Extend each operand to 64 bits by its signedness; the low 64 bits of the
  // wrapped product equal the true product for every op.
  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] x, y, p;
    x = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
    y = (o == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
    p = x * y;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic start_req(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    for (int t = 0; t < 100 && !in_ready; t++) @(negedge clk);
    check("in_ready before request", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    op       = o;
    rs1      = a;
    rs2      = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = 2'($urandom_range(0, 3));
    rs1      = $urandom;
    rs2      = $urandom;
  endtask

  // Edges are counted with the accepting edge as number 1.
  task automatic wait_valid(output int edges);
    edges = 1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      edges++;
    end
    check("out_valid within budget", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic finish_req(input string name, input logic [31:0] exp);
    int edges;
    wait_valid(edges);
    check({name, " latency"}, edges, 34);
    check({name, " result"}, result, exp);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, " in_ready after handshake"}, {31'd0, in_ready}, 32'd1);
    check({name, " out_valid after handshake"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic run_req(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    start_req(o, a, b);
    finish_req(name, exp);
  endtask

  initial begin
    int edges;
    logic [31:0] exp;
    logic [31:0] a, b;
    logic [1:0]  o;
    logic        seen;

    tbl[0] = '{2'b00, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A};
    tbl[1] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    tbl[2] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[3] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[4] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[5] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    tbl[6] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
    tbl[7] = '{2'b11, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001};
    tbl[8] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    tbl[9] = '{2'b01, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 2'b00;
    rs1       = '0;
    rs2       = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #12;
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_req($sformatf("table[%0d]", i), tbl[i].o, tbl[i].a, tbl[i].b, tbl[i].exp);
    end

    // Backpressure: result held in DONE while out_ready is low.
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    exp = ref_model(2'b11, a, b);
    start_req(2'b11, a, b);
    wait_valid(edges);
    check("bp latency", edges, 34);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp out_valid held", {31'd0, out_valid}, 32'd1);
      check("bp result held", result, exp);
      check("bp in_ready low", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp in_ready after handshake", {31'd0, in_ready}, 32'd1);

    // Flush during the tenth CALC cycle.
    start_req(2'b00, 32'h1111_1111, 32'h2222_2222);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush in_ready", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check("flush no out_valid", {31'd0, seen}, 32'd0);
    run_req("after flush 3x5", 2'b00, 32'd3, 32'd5, 32'h0000_000F);

    // Flush wins over out_ready in DONE.
    start_req(2'b00, 32'd9, 32'd9);
    wait_valid(edges);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    out_ready = 1'b0;
    check("flush in DONE out_valid", {31'd0, out_valid}, 32'd0);
    check("flush in DONE in_ready", {31'd0, in_ready}, 32'd1);

    // Asynchronous reset mid-CALC, away from any clock edge.
    start_req(2'b01, 32'h8765_4321, 32'h1357_9BDF);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", {31'd0, out_valid}, 32'd0);
    check("async reset in_ready", {31'd0, in_ready}, 32'd1);
    check("async reset result", result, 32'd0);
    #1;
    rst_n = 1'b1;
    run_req("after reset", 2'b10, 32'hFFFF_FFF0, 32'd16, ref_model(2'b10, 32'hFFFF_FFF0, 32'd16));

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       a = 32'h8000_0000;
        1:       a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       b = 32'h8000_0000;
        1:       b = 32'h7FFF_FFFF;
        default: b = $urandom;
      endcase
      run_req($sformatf("rand[%0d] op=%0d a=%h b=%h", i, o, a, b), o, a, b, ref_model(o, a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
